// File: rtl/hdmi_tx_config_if.sv
// Pin and status bundle of the HDMI transmitter configurator.
// The master side is the configurator; the slave side is its surroundings.
interface hdmi_tx_config_if;
  logic       start;
  logic       hpd;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] idx;

  modport master (
    input  start, hpd, sda_in,
    output scl_oe, sda_oe, busy, done, error, idx
  );
  modport slave (
    output start, hpd, sda_in,
    input  scl_oe, sda_oe, busy, done, error, idx
  );
endinterface

// File: rtl/hdmi_tx_config.sv
// I2C write-only configurator for an HDMI transmitter: after power settle it writes a
// fixed 12-entry register table, retrying NACKed entries, and re-runs on start or hot-plug.
module hdmi_tx_config #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned I2C_HZ     = 100000,
  parameter logic [6:0]  DEV_ADDR   = 7'h39,
  parameter int unsigned PWR_CYCLES = 10000000,
  parameter int unsigned MAX_TRY    = 3
) (
  input logic              clock50,
  input logic              reset,
  hdmi_tx_config_if.master bus
);

  localparam int unsigned Q_RAW    = CLK_HZ / (4 * I2C_HZ);
  localparam int unsigned Q        = (Q_RAW == 0) ? 1 : Q_RAW;
  localparam int unsigned QW       = (Q > 1) ? $clog2(Q) : 1;
  localparam int unsigned PWR_LAST = (PWR_CYCLES > 0) ? PWR_CYCLES - 1 : 0;
  localparam int unsigned PW       = (PWR_CYCLES > 1) ? $clog2(PWR_CYCLES) : 1;
  localparam int unsigned TRY_LAST = (MAX_TRY > 0) ? MAX_TRY - 1 : 0;
  localparam int unsigned TW       = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
  localparam logic [3:0]  LAST_IDX = 4'd11;

  typedef enum logic [3:0] {
    IDLE, WAIT_PWR, START, BIT, ACK, STOP, GAP, DONE, ERR
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [TW-1:0]   try_q, try_d;
  logic [3:0]      idx_q, idx_d;
  logic [PW-1:0]   pwr_q, pwr_d;
  logic            nack_q, nack_d;
  logic            abort_q, abort_d;
  logic            armed_q, armed_d;
  logic            hpd_s1_q, hpd_s2_q, hpd_d3_q;
  logic            scl_oe_q, scl_oe_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            tick_c, hpd_rise_c, hpd_fall_c, req_c;
  logic [15:0]     entry_c;
  logic [7:0]      cur_byte_c;

  function automatic logic [15:0] table_entry(input logic [3:0] i);
    logic [15:0] e;
    unique case (i)
      4'd0:    e = 16'h4110;
      4'd1:    e = 16'h9803;
      4'd2:    e = 16'h9AE0;
      4'd3:    e = 16'h9C30;
      4'd4:    e = 16'h9D61;
      4'd5:    e = 16'hA2A4;
      4'd6:    e = 16'hA3A4;
      4'd7:    e = 16'hE0D0;
      4'd8:    e = 16'hF900;
      4'd9:    e = 16'h1500;
      4'd10:   e = 16'h1630;
      default: e = 16'hAF06;
    endcase
    return e;
  endfunction

  assign tick_c     = (qcnt_q == QW'(Q - 1));
  assign hpd_rise_c = hpd_s2_q & ~hpd_d3_q;
  assign hpd_fall_c = ~hpd_s2_q & hpd_d3_q;
  // A start pulse and an hpd rise in the same cycle collapse into one request.
  assign req_c      = bus.start | hpd_rise_c;

  always_ff @(posedge clock50 or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      qcnt_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      try_q    <= '0;
      idx_q    <= '0;
      pwr_q    <= '0;
      nack_q   <= 1'b0;
      abort_q  <= 1'b0;
      armed_q  <= 1'b0;
      hpd_s1_q <= 1'b0;
      hpd_s2_q <= 1'b0;
      hpd_d3_q <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      qcnt_q   <= qcnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      try_q    <= try_d;
      idx_q    <= idx_d;
      pwr_q    <= pwr_d;
      nack_q   <= nack_d;
      abort_q  <= abort_d;
      armed_q  <= armed_d;
      hpd_s1_q <= bus.hpd;
      hpd_s2_q <= hpd_s1_q;
      hpd_d3_q <= hpd_s2_q;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    qcnt_d     = qcnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    try_d      = try_q;
    idx_d      = idx_q;
    pwr_d      = pwr_q;
    nack_d     = nack_q;
    abort_d    = abort_q;
    armed_d    = armed_q;
    entry_c    = '0;
    cur_byte_c = '0;
    scl_oe_d   = 1'b0;
    sda_oe_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;

    // An unplug mid-transaction lets the wire protocol finish, then parks in IDLE.
    if (hpd_fall_c && busy_q) abort_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!armed_q || req_c) begin
          state_d = WAIT_PWR;
          armed_d = 1'b1;
          idx_d   = '0;
          try_d   = '0;
          pwr_d   = '0;
          abort_d = 1'b0;
        end
      end
      WAIT_PWR: begin
        if (hpd_fall_c) begin
          state_d = IDLE;
          abort_d = 1'b0;
        end else if (pwr_q == PW'(PWR_LAST)) begin
          state_d = START;
        end else begin
          pwr_d = pwr_q + PW'(1);
        end
      end
      START: begin
        if (tick_c) begin
          if (phase_q == 2'd2) begin
            state_d = BIT;
            bit_d   = 3'd7;
            byte_d  = 2'd0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      BIT: begin
        if (tick_c) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (bit_q == 3'd0) state_d = ACK;
            else               bit_d   = bit_q - 3'd1;
          end
        end
      end
      ACK: begin
        if (tick_c) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd2) begin
            nack_d = bus.sda_in;
          end else if (phase_q == 2'd3) begin
            if (nack_q || byte_q == 2'd2) begin
              state_d = STOP;
            end else begin
              state_d = BIT;
              byte_d  = byte_q + 2'd1;
              bit_d   = 3'd7;
            end
          end
        end
      end
      STOP: begin
        if (tick_c) begin
          if (phase_q == 2'd2) state_d = GAP;
          else                 phase_d = phase_q + 2'd1;
        end
      end
      GAP: begin
        if (tick_c) begin
          if (phase_q != 2'd3) begin
            phase_d = phase_q + 2'd1;
          end else if (abort_d) begin
            state_d = IDLE;
            abort_d = 1'b0;
          end else if (nack_q) begin
            if (try_q == TW'(TRY_LAST)) begin
              state_d = ERR;
            end else begin
              state_d = START;
              try_d   = try_q + TW'(1);
            end
          end else if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = START;
            idx_d   = idx_q + 4'd1;
            try_d   = '0;
          end
        end
      end
      DONE, ERR: begin
        if (hpd_fall_c && state_q == DONE) begin
          state_d = IDLE;
        end else if (req_c) begin
          state_d = WAIT_PWR;
          idx_d   = '0;
          try_d   = '0;
          pwr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      qcnt_d  = '0;
      phase_d = 2'd0;
    end else if (tick_c) begin
      qcnt_d = '0;
    end else begin
      qcnt_d = qcnt_q + QW'(1);
    end

    // Line levels are decoded from the next state so the pins leave a flop.
    entry_c = table_entry(idx_d);
    unique case (byte_d)
      2'd0:    cur_byte_c = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte_c = entry_c[15:8];
      default: cur_byte_c = entry_c[7:0];
    endcase

    unique case (state_d)
      START: begin
        sda_oe_d = (phase_d != 2'd0);
        scl_oe_d = (phase_d == 2'd2);
      end
      BIT: begin
        scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
        sda_oe_d = ~cur_byte_c[bit_d];
      end
      ACK: begin
        scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
      end
      STOP: begin
        scl_oe_d = (phase_d == 2'd0);
        sda_oe_d = (phase_d != 2'd2);
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase

    busy_d  = (state_d inside {WAIT_PWR, START, BIT, ACK, STOP, GAP});
    done_d  = (state_d == DONE);
    error_d = (state_d == ERR);
  end

  assign bus.scl_oe = scl_oe_q;
  assign bus.sda_oe = sda_oe_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.error  = error_q;
  assign bus.idx    = idx_q;

endmodule
